spm_serial_driver: RTL and testbench
====================================

// Module: spm_serial_driver
// PURPOSE
//   Initiator/collector for the serial-parallel multiplier (spm). Accepts a parallel
//   operand pair, holds x on spm_x, and shifts y LSB-first into spm_y. Deserialises
//   the serial product from spm_p into a 2*WIDTH-bit word and returns it on a
//   valid/ready interface. Sits between the bus-side register block and the spm core.
// PARAMETERS
//   WIDTH   32  operand width in bits; product is 2*WIDTH bits
//   P_LAT   1   cycles from driving y bit k on spm_y to product bit k on spm_p (>=0)
//   SIGNED  0   1: y sign-extended during upper WIDTH shift cycles; 0: zero-filled
// PORTS
//   clk         in   1        single clock, all logic rising-edge
//   rst         in   1        synchronous active-high reset
//   in_valid    in   1        operand pair valid
//   in_ready    out  1        high only in IDLE
//   in_x        in   WIDTH    parallel multiplicand
//   in_y        in   WIDTH    multiplier, serialised LSB-first
//   spm_rst     out  1        clear to spm core, synchronous active-high
//   spm_x       out  WIDTH    held multiplicand, stable for whole operation
//   spm_y       out  1        serial multiplier bit
//   spm_p       in   1        serial product bit from core
//   prod        out  2*WIDTH  assembled product
//   prod_valid  out  1        product available
//   prod_ready  in   1        consumer accepts product
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE; in_ready=1 after reset; spm_rst=1; spm_x=0;
//     spm_y=0; prod=0; prod_valid=0; bit counter=0. rst overrides everything, any state.
//   FSM IDLE -> CLEAR -> SHIFT -> DONE -> IDLE.
//   IDLE: in_ready=1, spm_rst=1. in_valid&in_ready at edge: latch in_x->spm_x,
//     in_y->shift reg, go CLEAR. No other transfers accepted until back in IDLE.
//   CLEAR: exactly 1 cycle, spm_rst=1, spm_y=0; clears core partial sums. -> SHIFT.
//   SHIFT: spm_rst=0. Counter c runs 0 .. 2*WIDTH+P_LAT-1, one per cycle.
//     Drive cycle c: spm_y = y[c] for c<WIDTH; for c>=WIDTH spm_y = SIGNED ? y[WIDTH-1] : 0.
//     Capture: for c>=P_LAT, spm_p sampled into prod bit (c-P_LAT); bits shift in
//     from MSB side so bit 0 lands at prod[0] after last capture.
//     Captures with index >=2*WIDTH are not generated. Total SHIFT = 2*WIDTH+P_LAT cycles.
//     Last cycle -> DONE.
//   DONE: prod_valid=1, prod stable, spm_rst=1. prod_valid&prod_ready at edge ->
//     IDLE, prod_valid=0 next cycle. prod_ready ignored outside DONE.
//   Latency: accept edge to prod_valid = 2*WIDTH+P_LAT+2 cycles (IDLE->CLEAR->SHIFT...).
//   Throughput: one product per 2*WIDTH+P_LAT+3 cycles minimum (incl. IDLE cycle).
//   spm_x and y shift reg unchanged from accept until DONE handshake.
//   Counter width = clog2(2*WIDTH+P_LAT+1); no wrap inside an operation.
//   in_valid while busy: held by producer, no effect; no drop, no queue.
//   Reset mid-SHIFT: abort, prod and prod_valid cleared, no partial result presented.
//   prod not updated in IDLE/CLEAR; only written during SHIFT captures.
// TESTING
//   WIDTH=8,P_LAT=1,SIGNED=0 with reference spm: x=8'd13,y=8'd11 -> prod=16'd143,
//     prod_valid exactly 19 cycles after accept edge.
//   Boundaries: x=8'hFF,y=8'hFF -> 16'hFE01; x=0,y=8'hA5 -> 0; x=1,y=8'h80 -> 16'h0080.
//   Back-pressure: hold prod_ready=0 for 10 cycles in DONE -> prod_valid stays 1,
//     prod stable, in_ready stays 0; release -> IDLE next cycle, in_ready=1.
//   Busy input: in_valid held high across whole op with changing in_x/in_y ->
//     only first pair used; second pair accepted only in following IDLE cycle.
//   Reset at SHIFT c=5 -> next cycle IDLE, prod=0, prod_valid=0, spm_rst=1;
//     fresh op x=3,y=5 then yields 15.
//   Model check vs behavioural core stub, P_LAT=0 and 2, SIGNED=1: x=8'd2,y=8'hFF
//     (-1) -> spm_y stream y bits then eight 1s; prod matches core stream bit-exact.

Source files
------------

// File: rtl/spm_serial_driver_if.sv
// Operand/product handshake bundle between the bus-side register block and spm_serial_driver.
// Latency: none, pure wiring.
// Backpressure: in_valid/in_ready on the operand side, prod_valid/prod_ready on the product side.
//
// Signals:
//   in_valid/in_ready    operand pair handshake (in_ready driven by the driver)
//   in_x/in_y            parallel multiplicand / multiplier, WIDTH bits each
//   prod/prod_valid      assembled 2*WIDTH-bit product and its valid flag
//   prod_ready           consumer accepts product
// Modports: master = bus-side producer/consumer, slave = spm_serial_driver.
interface spm_serial_driver_if #(
    parameter int WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_x;
    logic [WIDTH-1:0]       in_y;
    logic [2*WIDTH-1:0]     prod;
    logic                   prod_valid;
    logic                   prod_ready;

    modport master (
        output in_valid, in_x, in_y, prod_ready,
        input  in_ready, prod, prod_valid
    );

    modport slave (
        input  in_valid, in_x, in_y, prod_ready,
        output in_ready, prod, prod_valid
    );
endinterface

// File: rtl/spm_serial_driver.sv
// Drives a serial-parallel multiplier: holds x, streams y LSB-first, deserialises the product.
// Latency: 2*WIDTH+P_LAT+2 edges from the accept edge (inclusive) to prod_valid.
// Backpressure: in_ready only in IDLE; product held in DONE until prod_ready.
//
// Ports:
//   clk, rst      single rising-edge clock, synchronous active-high reset
//   bus           operand/product handshake (spm_serial_driver_if.slave)
//   spm_rst       clear to the spm core, high outside SHIFT
//   spm_x         multiplicand held for the whole operation
//   spm_y         serial multiplier bit (sign- or zero-extended for the upper WIDTH cycles)
//   spm_p         serial product bit returned by the core, P_LAT cycles after spm_y
module spm_serial_driver #(
    parameter int WIDTH  = 32,
    parameter int P_LAT  = 1,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst,
    spm_serial_driver_if.slave  bus,
    output logic                spm_rst,
    output logic [WIDTH-1:0]    spm_x,
    output logic                spm_y,
    input  logic                spm_p
);
    localparam int SHIFT_LEN = 2 * WIDTH + P_LAT;
    localparam int CW        = $clog2(SHIFT_LEN + 1);
    localparam int YIW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] LAST_C  = CW'(SHIFT_LEN - 1);
    localparam logic [CW-1:0] LAT_C   = CW'(P_LAT);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_inc;
    logic [WIDTH-1:0]   y_reg;
    logic [2*WIDTH-1:0] prod_q;
    logic               y_bit;
    logic               cap_en;

    assign cnt_inc = cnt + CW'(1);

    // y is kept intact for the whole operation and indexed by the counter
    // rather than shifted, so it can still be observed after the product is out.
    always_comb begin
        y_bit = 1'b0;
        if (cnt < WIDTH_C) begin
            y_bit = y_reg[cnt[YIW-1:0]];
        end else if (SIGNED != 0) begin
            y_bit = y_reg[WIDTH-1];
        end
    end

    // Product bit k returns P_LAT cycles after y bit k, so capturing starts at
    // cnt == P_LAT. Written as cnt+1 > P_LAT to stay meaningful when P_LAT == 0.
    assign cap_en = (state == ST_SHIFT) && (cnt_inc > LAT_C);

    assign spm_y          = (state == ST_SHIFT) ? y_bit : 1'b0;
    assign spm_rst        = (state != ST_SHIFT);
    assign bus.in_ready   = (state == ST_IDLE);
    assign bus.prod_valid = (state == ST_DONE);
    assign bus.prod       = prod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            spm_x  <= '0;
            y_reg  <= '0;
            prod_q <= '0;
        end else begin
            // Bits enter at the MSB so the first captured bit ends at prod[0].
            if (cap_en) begin
                prod_q <= {spm_p, prod_q[2*WIDTH-1:1]};
            end

            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        spm_x <= bus.in_x;
                        y_reg <= bus.in_y;
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnt == LAST_C) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_DONE: begin
                    if (bus.prod_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spm_serial_driver.sv
// Directed bench for spm_serial_driver with a behavioural spm core per configuration.
// cfg[0]: P_LAT=1 SIGNED=0, cfg[1]: P_LAT=0 SIGNED=1, cfg[2]: P_LAT=2 SIGNED=1 (all WIDTH=8).
// Latency counts edges from the accept edge (counted as 1) to the first cycle with prod_valid.
module tb_spm_serial_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid   [3];
    logic [7:0] in_x       [3];
    logic [7:0] in_y       [3];
    logic       prod_ready [3];

    wire        in_ready_w   [3];
    wire        prod_valid_w [3];
    wire [15:0] prod_w       [3];
    wire        spm_rst_w    [3];
    wire        spm_y_w      [3];
    wire [7:0]  spm_x_w      [3];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int PL = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
        localparam int SG = (g == 0) ? 0 : 1;

        spm_serial_driver_if #(.WIDTH(8)) bus ();
        logic       spm_rst;
        logic       spm_y;
        logic       spm_p;
        logic [7:0] spm_x;

        assign bus.in_valid   = in_valid[g];
        assign bus.in_x       = in_x[g];
        assign bus.in_y       = in_y[g];
        assign bus.prod_ready = prod_ready[g];
        assign in_ready_w[g]   = bus.in_ready;
        assign prod_valid_w[g] = bus.prod_valid;
        assign prod_w[g]       = bus.prod;
        assign spm_rst_w[g]    = spm_rst;
        assign spm_y_w[g]      = spm_y;
        assign spm_x_w[g]      = spm_x;

        spm_serial_driver #(.WIDTH(8), .P_LAT(PL), .SIGNED(SG)) dut (
            .clk     (clk),
            .rst     (rst),
            .bus     (bus),
            .spm_rst (spm_rst),
            .spm_x   (spm_x),
            .spm_y   (spm_y),
            .spm_p   (spm_p)
        );

        // Core stub: accumulates x*y_k*2^k; bit k of the running sum is final at step k.
        logic [15:0] acc;
        logic [15:0] cur;
        logic [4:0]  k;
        logic [1:0]  dly;
        logic        pnow;
        logic [2:0]  pipe;

        always_comb begin
            cur  = acc + (spm_y ? ({8'd0, spm_x} << k) : 16'd0);
            pnow = (k < 5'd16) ? cur[k[3:0]] : 1'b0;
            pipe = {dly, pnow};
        end
        assign spm_p = pipe[PL];

        always_ff @(posedge clk) begin
            if (spm_rst) begin
                acc <= 16'd0;
                k   <= 5'd0;
                dly <= 2'd0;
            end else begin
                acc <= cur;
                k   <= k + 5'd1;
                dly <= {dly[0], pnow};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assumes the selected driver is in IDLE; completes the product handshake.
    task automatic run_op(input int g, input logic [7:0] x, input logic [7:0] y,
                          output logic [15:0] p, output int lat);
        in_valid[g] = 1'b1;
        in_x[g]     = x;
        in_y[g]     = y;
        tick();
        in_valid[g] = 1'b0;
        lat = 1;
        while (prod_valid_w[g] !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        p = prod_w[g];
        prod_ready[g] = 1'b1;
        tick();
        prod_ready[g] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (in_ready_w[0] !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready_w[0]); end
        checks++; if (spm_rst_w[0] !== 1'b1) begin errors++; $display("FAIL reset_spm_rst got=%b want=1", spm_rst_w[0]); end
        checks++; if (spm_x_w[0] !== 8'd0) begin errors++; $display("FAIL reset_spm_x got=%h want=00", spm_x_w[0]); end
        checks++; if (spm_y_w[0] !== 1'b0) begin errors++; $display("FAIL reset_spm_y got=%b want=0", spm_y_w[0]); end
        checks++; if (prod_w[0] !== 16'd0) begin errors++; $display("FAIL reset_prod got=%h want=0000", prod_w[0]); end
        checks++; if (prod_valid_w[0] !== 1'b0) begin errors++; $display("FAIL reset_prod_valid got=%b want=0", prod_valid_w[0]); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] p;
        int lat;
        run_op(0, 8'd13, 8'd11, p, lat);
        checks++; if (p !== 16'd143) begin errors++; $display("FAIL basic_prod got=%0d want=143", p); end
        checks++; if (lat !== 19) begin errors++; $display("FAIL basic_latency got=%0d want=19", lat); end
    endtask

    task automatic test_boundaries();
        logic [7:0]  xs [3] = '{8'hFF, 8'h00, 8'h01};
        logic [7:0]  ys [3] = '{8'hFF, 8'hA5, 8'h80};
        logic [15:0] es [3] = '{16'hFE01, 16'h0000, 16'h0080};
        logic [15:0] p;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(0, xs[i], ys[i], p, lat);
            checks++; if (p !== es[i]) begin errors++; $display("FAIL boundary_prod[%0d] got=%h want=%h", i, p, es[i]); end
            checks++; if (lat !== 19) begin errors++; $display("FAIL boundary_latency[%0d] got=%0d want=19", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        in_valid[0] = 1'b1; in_x[0] = 8'd7; in_y[0] = 8'd9;
        tick();
        in_valid[0] = 1'b0;
        n = 0;
        while (prod_valid_w[0] !== 1'b1 && n < 100) begin tick(); n++; end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({prod_valid_w[0], in_ready_w[0], prod_w[0]} !== {1'b1, 1'b0, 16'd63}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d] got valid=%b ready=%b prod=%0d want valid=1 ready=0 prod=63",
                         i, prod_valid_w[0], in_ready_w[0], prod_w[0]);
            end
        end
        prod_ready[0] = 1'b1;
        tick();
        prod_ready[0] = 1'b0;
        checks++; if (prod_valid_w[0] !== 1'b0) begin errors++; $display("FAIL backpressure_release_valid got=%b want=0", prod_valid_w[0]); end
        checks++; if (in_ready_w[0] !== 1'b1) begin errors++; $display("FAIL backpressure_release_ready got=%b want=1", in_ready_w[0]); end
    endtask

    task automatic test_busy_input();
        int n;
        in_valid[0] = 1'b1; in_x[0] = 8'd13; in_y[0] = 8'd11;
        tick();
        in_x[0] = 8'd5; in_y[0] = 8'd6;
        n = 0;
        while (prod_valid_w[0] !== 1'b1 && n < 100) begin
            checks++;
            if ({in_ready_w[0], spm_x_w[0]} !== {1'b0, 8'd13}) begin
                errors++;
                $display("FAIL busy_hold[%0d] got ready=%b spm_x=%0d want ready=0 spm_x=13", n, in_ready_w[0], spm_x_w[0]);
            end
            tick();
            n++;
        end
        checks++; if (prod_w[0] !== 16'd143) begin errors++; $display("FAIL busy_first_prod got=%0d want=143", prod_w[0]); end
        prod_ready[0] = 1'b1;
        tick();
        prod_ready[0] = 1'b0;
        checks++; if (in_ready_w[0] !== 1'b1) begin errors++; $display("FAIL busy_idle_ready got=%b want=1", in_ready_w[0]); end
        checks++; if (spm_x_w[0] !== 8'd13) begin errors++; $display("FAIL busy_idle_spm_x got=%0d want=13", spm_x_w[0]); end
        tick();
        in_valid[0] = 1'b0;
        checks++; if (in_ready_w[0] !== 1'b0) begin errors++; $display("FAIL busy_second_accept_ready got=%b want=0", in_ready_w[0]); end
        checks++; if (spm_x_w[0] !== 8'd5) begin errors++; $display("FAIL busy_second_spm_x got=%0d want=5", spm_x_w[0]); end
        n = 0;
        while (prod_valid_w[0] !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (prod_w[0] !== 16'd30) begin errors++; $display("FAIL busy_second_prod got=%0d want=30", prod_w[0]); end
        prod_ready[0] = 1'b1;
        tick();
        prod_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        logic [15:0] p;
        int lat;
        in_valid[0] = 1'b1; in_x[0] = 8'd9; in_y[0] = 8'd9;
        tick();                      // CLEAR
        in_valid[0] = 1'b0;
        tick();                      // SHIFT c=0
        repeat (5) tick();           // SHIFT c=5
        checks++; if (spm_rst_w[0] !== 1'b0) begin errors++; $display("FAIL midreset_in_shift got spm_rst=%b want=0", spm_rst_w[0]); end
        checks++; if (spm_y_w[0] !== 1'b0) begin errors++; $display("FAIL midreset_spm_y_c5 got=%b want=0", spm_y_w[0]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (in_ready_w[0] !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got=%b want=1", in_ready_w[0]); end
        checks++; if (prod_w[0] !== 16'd0) begin errors++; $display("FAIL midreset_prod got=%h want=0000", prod_w[0]); end
        checks++; if (prod_valid_w[0] !== 1'b0) begin errors++; $display("FAIL midreset_prod_valid got=%b want=0", prod_valid_w[0]); end
        checks++; if (spm_rst_w[0] !== 1'b1) begin errors++; $display("FAIL midreset_spm_rst got=%b want=1", spm_rst_w[0]); end
        run_op(0, 8'd3, 8'd5, p, lat);
        checks++; if (p !== 16'd15) begin errors++; $display("FAIL midreset_fresh_prod got=%0d want=15", p); end
    endtask

    task automatic test_model_signed();
        logic [7:0]  xs [2] = '{8'd2, 8'd3};
        logic [7:0]  ys [2] = '{8'hFF, 8'hFE};
        logic [15:0] ps [2] = '{16'hFFFE, 16'hFFFA};
        logic [23:0] stream;
        logic [23:0] exp_s;
        int pl, lat, nsh;
        for (int g = 1; g < 3; g++) begin
            pl = (g == 1) ? 0 : 2;
            for (int v = 0; v < 2; v++) begin
                // y bits LSB-first then sign fill: all ones, except bit 0 for y=FE.
                exp_s = (24'd1 << (16 + pl)) - 24'd1 - ((v == 1) ? 24'd1 : 24'd0);
                stream = 24'd0;
                nsh = 0;
                in_valid[g] = 1'b1; in_x[g] = xs[v]; in_y[g] = ys[v];
                tick();
                in_valid[g] = 1'b0;
                lat = 1;
                while (prod_valid_w[g] !== 1'b1 && lat < 100) begin
                    if (spm_rst_w[g] === 1'b0 && nsh < 24) begin
                        stream[nsh] = spm_y_w[g];
                        nsh++;
                    end
                    tick();
                    lat++;
                end
                checks++; if (nsh !== 16 + pl) begin errors++; $display("FAIL model_shift_len cfg%0d v%0d got=%0d want=%0d", g, v, nsh, 16 + pl); end
                checks++; if (stream !== exp_s) begin errors++; $display("FAIL model_y_stream cfg%0d v%0d got=%h want=%h", g, v, stream, exp_s); end
                checks++; if (prod_w[g] !== ps[v]) begin errors++; $display("FAIL model_prod cfg%0d v%0d got=%h want=%h", g, v, prod_w[g], ps[v]); end
                checks++; if (lat !== 18 + pl) begin errors++; $display("FAIL model_latency cfg%0d v%0d got=%0d want=%0d", g, v, lat, 18 + pl); end
                prod_ready[g] = 1'b1;
                tick();
                prod_ready[g] = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]   = 1'b0;
            in_x[i]       = 8'd0;
            in_y[i]       = 8'd0;
            prod_ready[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_busy_input();
        test_reset_mid_shift();
        test_model_signed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
